rgb_fade_sequencer: RTL and testbench
=====================================

RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 625000, clk cycles per fade step (minimum 2).
REQ-002 SHALL have parameter DWELL_TICKS, default 16, fade steps held at full target colour (minimum 1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins sequence from IDLE; ignored when busy=1.
REQ-006 SHALL have port stop, input, 1, aborts to IDLE.
REQ-007 SHALL have port pause, input, 1, level; freezes step counter and FSM while high.
REQ-008 SHALL have ports r_duty, g_duty and b_duty, each output, 8, channel duty value driven to the PWM stage.
REQ-009 SHALL have port color_idx, output, 3, palette index of the current colour (0..6).
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port seg_done, output, 1, one-cycle pulse when a colour segment completes.

Function
REQ-012 SHALL use this palette (R,G,B), indexed 0..6: red 255,0,0; orange 255,60,0; yellow 255,255,0; green 0,255,0; blue 0,0,255; indigo 8,46,84; purple 160,32,240.
REQ-013 SHALL derive a one-cycle step strobe from a counter 0..TICK_DIV-1, strobing when count==TICK_DIV-1, with no derived clocks.
REQ-014 SHALL keep the step counter at 0 in IDLE and clear it on entry from IDLE.
REQ-015 SHALL use FSM states IDLE, RAMP_UP, HOLD, RAMP_DOWN and NEXT; transitions other than start/stop occur only on a strobe.
REQ-016 In IDLE with start=1 and stop=0, the FSM SHALL enter RAMP_UP with color_idx=0 and all duties 0 at the next edge (busy=1 one cycle after start).
REQ-017 In RAMP_UP, on each strobe, each channel below its target SHALL increment by 1; a channel already at target SHALL stay.
REQ-018 A target of 0 SHALL count as reached immediately.
REQ-019 When all three channels equal their targets after a strobe update, the FSM SHALL enter HOLD with the dwell counter cleared.
REQ-020 HOLD SHALL keep the duties constant and count strobes; after DWELL_TICKS strobes it SHALL enter RAMP_DOWN.
REQ-021 In RAMP_DOWN, on each strobe, each nonzero channel SHALL decrement by 1, saturating at 0; when all are 0 the FSM SHALL enter NEXT.
REQ-022 NEXT SHALL last one clk cycle: it pulses seg_done, sets color_idx to (color_idx+1) mod 7 with 6 wrapping to 0, then enters RAMP_UP.
REQ-023 Duty arithmetic SHALL be 8-bit and SHALL never wrap: no 255->0 on increment and no 0->255 on decrement.
REQ-024 stop=1 SHALL force IDLE at the next edge with duties 0, color_idx 0, busy 0 and seg_done 0.
REQ-025 If start and stop are high in the same cycle, stop SHALL win.
REQ-026 pause=1 SHALL hold the step counter, dwell counter, FSM state and duties unchanged.
REQ-027 stop SHALL override pause.
REQ-028 Releasing pause SHALL resume counting from the frozen count.

Reset
REQ-029 rst=1 at a clk edge SHALL give state IDLE, r_duty=g_duty=b_duty=0, color_idx=0, busy=0, seg_done=0, step and dwell counters 0.
REQ-030 rst SHALL take priority over start, stop and pause, including in mid-ramp or mid-hold.

Structure
REQ-031 Shared package rgb_pkg SHALL hold the palette constants, NUM_COLORS=7, the FSM state encoding and the 8-bit duty width constant.
REQ-032 The step strobe SHALL be a sub-module tick_gen (parameter TICK_DIV; inputs clk, rst, clr, hold; output tick).
REQ-033 All duty outputs SHALL be registered.

Verification (TICK_DIV=4, DWELL_TICKS=2)
REQ-034 Bench SHALL check: rst pulse -> all outputs 0, busy 0, color_idx 0.
REQ-035 Bench SHALL check: start -> r_duty reaches 255 after 255 strobes (1020 cycles), then holds for 2 strobes, then ramps down 255 strobes; seg_done pulses once; color_idx=1; g_duty and b_duty stay 0 throughout.
REQ-036 Bench SHALL check orange segment: g_duty stops at 60 while r_duty continues to 255; HOLD entered only when r=255 and g=60; no value exceeds its target.
REQ-037 Bench SHALL check: run through purple (color_idx 6) -> seg_done pulse, color_idx wraps to 0, r_duty restarts from 0.
REQ-038 Bench SHALL check: pause for 50 cycles mid-RAMP_UP at r_duty=100 -> r_duty stays 100 and the strobe is absent; after release the next strobe arrives after the remaining count and r_duty=101.
REQ-039 Bench SHALL check: stop during HOLD; start and stop in the same cycle while IDLE; rst mid-RAMP_DOWN -> each gives IDLE with all duties 0, busy 0, color_idx 0 next cycle; a start while busy is ignored.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared definitions for the RGB fade sequencer.
//   - duty width and palette size
//   - packed RGB triple type and the 7-entry palette
//   - FSM state encoding
package rgb_pkg;

  localparam int unsigned DUTY_W     = 8;
  localparam int unsigned NUM_COLORS = 7;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_NEXT      = 3'd4
  } state_e;

  localparam rgb_t COLOR_RED    = '{r: 8'd255, g: 8'd0,   b: 8'd0};
  localparam rgb_t COLOR_ORANGE = '{r: 8'd255, g: 8'd60,  b: 8'd0};
  localparam rgb_t COLOR_YELLOW = '{r: 8'd255, g: 8'd255, b: 8'd0};
  localparam rgb_t COLOR_GREEN  = '{r: 8'd0,   g: 8'd255, b: 8'd0};
  localparam rgb_t COLOR_BLUE   = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
  localparam rgb_t COLOR_INDIGO = '{r: 8'd8,   g: 8'd46,  b: 8'd84};
  localparam rgb_t COLOR_PURPLE = '{r: 8'd160, g: 8'd32,  b: 8'd240};

  function automatic rgb_t palette_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOR_RED;
      3'd1:    return COLOR_ORANGE;
      3'd2:    return COLOR_YELLOW;
      3'd3:    return COLOR_GREEN;
      3'd4:    return COLOR_BLUE;
      3'd5:    return COLOR_INDIGO;
      3'd6:    return COLOR_PURPLE;
      default: return COLOR_RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running step strobe generator.
//   clk   - clock
//   rst   - synchronous active-high reset (count to 0)
//   clr   - synchronous clear (count to 0), overrides hold
//   hold  - freeze the count; no strobe while high
//   tick  - one-cycle strobe when count == TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 625000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (!hold) begin
      tick    = (count_q == LAST);
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: steps through a 7-colour palette, ramping each colour
// up one duty unit per step strobe, holding it for DWELL_TICKS strobes,
// ramping it back down to black, then advancing to the next colour.
//   clk, rst            - clock, synchronous active-high reset
//   start / stop        - begin from IDLE / abort to IDLE (stop wins)
//   pause               - level; freezes step counter, dwell counter, FSM, duties
//   r_duty/g_duty/b_duty- registered 8-bit channel duties
//   color_idx           - current palette index 0..6
//   busy                - high in every state except IDLE
//   seg_done            - one-cycle pulse while in NEXT (segment complete)
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 625000,
  parameter int unsigned DWELL_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic [7:0] r_duty,
  output logic [7:0] g_duty,
  output logic [7:0] b_duty,
  output logic [2:0] color_idx,
  output logic       busy,
  output logic       seg_done
);

  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  state_e        state_q, state_d;
  rgb_t          duty_q, duty_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          seg_done_q, seg_done_d;

  logic step_tick;
  logic tick_clr;
  rgb_t target;
  rgb_t up_next;
  rgb_t down_next;

  // Counter sits at 0 in IDLE and stays cleared on the start edge, so the
  // first strobe of a sequence lands TICK_DIV cycles after busy rises.
  assign tick_clr = (state_q == ST_IDLE) || stop;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .hold (pause),
    .tick (step_tick)
  );

  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    return (cur < tgt) ? cur + 8'd1 : cur;
  endfunction

  function automatic duty_t step_down(input duty_t cur);
    return (cur != '0) ? cur - 8'd1 : cur;
  endfunction

  always_comb begin
    target    = palette_color(idx_q);
    up_next   = '{r: step_toward(duty_q.r, target.r),
                  g: step_toward(duty_q.g, target.g),
                  b: step_toward(duty_q.b, target.b)};
    down_next = '{r: step_down(duty_q.r),
                  g: step_down(duty_q.g),
                  b: step_down(duty_q.b)};

    state_d    = state_q;
    duty_d     = duty_q;
    idx_d      = idx_q;
    dwell_d    = dwell_q;
    seg_done_d = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      idx_d   = '0;
      dwell_d = '0;
    end else if (!pause) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RAMP_UP;
            duty_d  = '0;
            idx_d   = '0;
            dwell_d = '0;
          end
        end
        ST_RAMP_UP: begin
          if (step_tick) begin
            duty_d = up_next;
            if (up_next == target) begin
              state_d = ST_HOLD;
              dwell_d = '0;
            end
          end
        end
        ST_HOLD: begin
          if (step_tick) begin
            if (dwell_q == DWELL_LAST) begin
              state_d = ST_RAMP_DOWN;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (step_tick) begin
            duty_d = down_next;
            if (down_next == '0) begin
              state_d    = ST_NEXT;
              seg_done_d = 1'b1;
            end
          end
        end
        ST_NEXT: begin
          idx_d   = (idx_q == 3'(NUM_COLORS - 1)) ? '0 : idx_q + 3'd1;
          state_d = ST_RAMP_UP;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          idx_d   = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      idx_q      <= '0;
      dwell_q    <= '0;
      seg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      seg_done_q <= seg_done_d;
    end
  end

  assign r_duty    = duty_q.r;
  assign g_duty    = duty_q.g;
  assign b_duty    = duty_q.b;
  assign color_idx = idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign seg_done  = seg_done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: self-checking bench for rgb_fade_sequencer with
// TICK_DIV=4, DWELL_TICKS=2. A segment-level model tracks the number of
// strobes k since the segment began; every duty follows directly from k.
module tb_rgb_fade_sequencer;

  localparam int TD = 4;
  localparam int DT = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause;
  logic [7:0] r_duty, g_duty, b_duty;
  logic [2:0] color_idx;
  logic       busy, seg_done;

  rgb_fade_sequencer #(.TICK_DIV(TD), .DWELL_TICKS(DT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .r_duty    (r_duty),
    .g_duty    (g_duty),
    .b_duty    (b_duty),
    .color_idx (color_idx),
    .busy      (busy),
    .seg_done  (seg_done)
  );

  always #5 clk = ~clk;

  int pal_r [7] = '{255, 255, 255,   0,   0,  8, 160};
  int pal_g [7] = '{  0,  60, 255, 255,   0, 46,  32};
  int pal_b [7] = '{  0,   0,   0,   0, 255, 84, 240};

  int n_cmp = 0;
  int n_bad = 0;

  // model
  bit m_busy, m_seg;
  int m_idx, m_k, m_cnt;

  // trackers
  int seg_count;
  int max_r, max_g, max_b;

  function automatic int seg_max(int i);
    int m;
    m = pal_r[i];
    if (pal_g[i] > m) m = pal_g[i];
    if (pal_b[i] > m) m = pal_b[i];
    return m;
  endfunction

  function automatic int exp_duty(int t);
    int mx, j;
    if (!m_busy) return 0;
    mx = seg_max(m_idx);
    if (m_k < mx) return (m_k < t) ? m_k : t;
    if (m_k < mx + DT) return t;
    j = m_k - mx - DT;
    return (t > j) ? t - j : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    int mx;
    bit strobe;
    m_seg = 1'b0;
    if (rst || stop) begin
      m_busy = 1'b0; m_idx = 0; m_k = 0; m_cnt = 0;
    end else if (pause) begin
      // frozen
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_idx = 0; m_k = 0; m_cnt = 0;
      end
    end else begin
      mx     = seg_max(m_idx);
      strobe = (m_cnt == TD - 1);
      m_cnt  = strobe ? 0 : m_cnt + 1;
      if (m_k == 2 * mx + DT) begin
        m_idx = (m_idx + 1) % 7;
        m_k   = 0;
      end else if (strobe) begin
        m_k++;
        if (m_k == 2 * mx + DT) m_seg = 1'b1;
      end
    end
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1;
      check("r_duty",    int'(r_duty),    exp_duty(pal_r[m_idx]));
      check("g_duty",    int'(g_duty),    exp_duty(pal_g[m_idx]));
      check("b_duty",    int'(b_duty),    exp_duty(pal_b[m_idx]));
      check("color_idx", int'(color_idx), m_idx);
      check("busy",      int'(busy),      int'(m_busy));
      check("seg_done",  int'(seg_done),  int'(m_seg));
      if (seg_done) seg_count++;
      if (int'(r_duty) > max_r) max_r = int'(r_duty);
      if (int'(g_duty) > max_g) max_g = int'(g_duty);
      if (int'(b_duty) > max_b) max_b = int'(b_duty);
    end
  endtask

  task automatic clear_trackers();
    seg_count = 0; max_r = 0; max_g = 0; max_b = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    m_busy = 1'b0; m_seg = 1'b0; m_idx = 0; m_k = 0; m_cnt = 0;
    clear_trackers();
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check("rst_r", int'(r_duty), 0);
    check("rst_g", int'(g_duty), 0);
    check("rst_b", int'(b_duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(color_idx), 0);

    // red segment, timing pinned to literal cycle counts
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    clear_trackers();
    check("start_busy", int'(busy), 1);
    check("start_r", int'(r_duty), 0);
    cycles(1019);
    check("red_r_1019", int'(r_duty), 254);
    cycles(1);
    check("red_r_1020", int'(r_duty), 255);
    cycles(8);
    check("red_hold_end", int'(r_duty), 255);
    cycles(4);
    check("red_down_first", int'(r_duty), 254);
    cycles(1016);
    check("red_down_zero", int'(r_duty), 0);
    check("red_seg_done", int'(seg_done), 1);
    check("red_idx_in_next", int'(color_idx), 0);
    cycles(1);
    check("red_idx_after", int'(color_idx), 1);
    check("red_seg_count", seg_count, 1);
    check("red_g_max", max_g, 0);
    check("red_b_max", max_b, 0);

    // orange segment with a pause at r=100
    clear_trackers();
    n = 0;
    while (r_duty != 8'd100 && n < 2000) begin cycles(1); n++; end
    check("wait_r100", int'(r_duty), 100);
    check("orange_g_at_r100", int'(g_duty), 60);
    pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      check("pause_r", int'(r_duty), 100);
      check("pause_tick", int'(dut.u_tick.tick), 0);
    end
    pause = 1'b0;
    cycles(3);
    check("resume_r_3", int'(r_duty), 100);
    cycles(1);
    check("resume_r_4", int'(r_duty), 101);
    n = 0;
    while (r_duty != 8'd255 && n < 2000) begin cycles(1); n++; end
    check("orange_r_peak", int'(r_duty), 255);
    check("orange_g_at_peak", int'(g_duty), 60);
    n = 0;
    while (color_idx != 3'd2 && n < 3000) begin cycles(1); n++; end
    check("orange_done_idx", int'(color_idx), 2);
    check("orange_g_max", max_g, 60);
    check("orange_b_max", max_b, 0);

    // run through purple and wrap
    n = 0;
    while (!(seg_done && color_idx == 3'd6) && n < 20000) begin cycles(1); n++; end
    check("purple_seg_done", int'(seg_done), 1);
    cycles(1);
    check("wrap_idx", int'(color_idx), 0);
    check("wrap_r", int'(r_duty), 0);
    cycles(2);
    check("wrap_r_pre", int'(r_duty), 0);
    cycles(1);
    check("wrap_r_first", int'(r_duty), 1);

    // start while busy is ignored
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("busy_start_busy", int'(busy), 1);
    check("busy_start_r", int'(r_duty), 1);

    // stop during HOLD
    n = 0;
    while (r_duty != 8'd255 && n < 1200) begin cycles(1); n++; end
    check("wait_red_hold", int'(r_duty), 255);
    cycles(2);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("stop_hold_r", int'(r_duty), 0);
    check("stop_hold_busy", int'(busy), 0);
    check("stop_hold_idx", int'(color_idx), 0);
    check("stop_hold_seg", int'(seg_done), 0);

    // start and stop together while IDLE
    start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 0);
    check("start_stop_r", int'(r_duty), 0);

    // rst mid RAMP_DOWN
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    n = 0;
    while (r_duty != 8'd255 && n < 1200) begin cycles(1); n++; end
    n = 0;
    while (r_duty != 8'd200 && n < 1200) begin cycles(1); n++; end
    check("wait_down_200", int'(r_duty), 200);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_down_r", int'(r_duty), 0);
    check("rst_down_busy", int'(busy), 0);
    check("rst_down_idx", int'(color_idx), 0);

    // randomized control traffic against the model
    for (int i = 0; i < 8000; i++) begin
      start = ($urandom % 64) == 0;
      stop  = ($urandom % 1500) == 0;
      rst   = ($urandom % 2500) == 0;
      if (pause) pause = ($urandom % 20) != 0;
      else       pause = ($urandom % 150) == 0;
      cycles(1);
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0; pause = 1'b0;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
